// File: rtl/rxd_command_decoder.sv
// 8N1 serial receiver and host command decoder for the ReadClock domain.
// Produces capture-path control pulses/levels and a simple register-write bus.
module rxd_command_decoder #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SDI,
  output logic [7:0] rxByte,
  output logic       rxByteValid,
  output logic       framingError,
  output logic       armTrigger,
  output logic       softReset,
  output logic       streamEnable,
  output logic [7:0] regAddr,
  output logic [7:0] regData,
  output logic       regWrite,
  output logic       cmdError
);

  localparam int unsigned BIT_W          = $clog2(CLKS_PER_BIT);
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_ADDR = 2'd1;
  localparam logic [1:0] CMD_DATA = 2'd2;

  logic             sdi_meta, sdi_sync, sdi_prev;
  logic [1:0]       primed;
  logic             seen_high;
  logic             start_edge;
  logic [1:0]       bit_state;
  logic [BIT_W-1:0] bit_timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [1:0]       cmd_state;
  logic [7:0]       addr_latch;
  logic [TO_W-1:0]  to_cnt;

  // primed marks when sdi_sync holds a real sample rather than its reset value,
  // so a line that is already low at reset release is never taken as a start bit.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sdi_meta  <= 1'b1;
      sdi_sync  <= 1'b1;
      sdi_prev  <= 1'b1;
      primed    <= 2'b00;
      seen_high <= 1'b0;
    end else begin
      sdi_meta  <= SDI;
      sdi_sync  <= sdi_meta;
      sdi_prev  <= sdi_sync;
      primed    <= {primed[0], 1'b1};
      seen_high <= seen_high | (primed[1] & sdi_sync);
    end
  end

  assign start_edge = seen_high & sdi_prev & ~sdi_sync;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bit_state    <= RX_IDLE;
      bit_timer    <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rxByte       <= '0;
      rxByteValid  <= 1'b0;
      framingError <= 1'b0;
    end else begin
      rxByteValid  <= 1'b0;
      framingError <= 1'b0;
      if (bit_timer != BIT_LAST) bit_timer <= bit_timer + 1'b1;
      case (bit_state)
        RX_IDLE: begin
          bit_timer <= '0;
          if (start_edge) bit_state <= RX_START;
        end
        RX_START: begin
          if (bit_timer == HALF_LAST) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            bit_state <= sdi_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_timer == BIT_LAST) begin
            bit_timer <= '0;
            shift_reg <= {sdi_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) bit_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_timer == BIT_LAST) begin
            bit_state <= RX_IDLE;
            if (sdi_sync) begin
              rxByte      <= shift_reg;
              rxByteValid <= 1'b1;
            end else begin
              framingError <= 1'b1;
            end
          end
        end
        default: bit_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cmd_state    <= CMD_IDLE;
      addr_latch   <= '0;
      to_cnt       <= '0;
      armTrigger   <= 1'b0;
      softReset    <= 1'b0;
      streamEnable <= 1'b0;
      regAddr      <= '0;
      regData      <= '0;
      regWrite     <= 1'b0;
      cmdError     <= 1'b0;
    end else begin
      armTrigger <= 1'b0;
      softReset  <= 1'b0;
      regWrite   <= 1'b0;
      cmdError   <= 1'b0;
      if (cmd_state == CMD_IDLE || rxByteValid) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
      case (cmd_state)
        CMD_IDLE: begin
          if (rxByteValid) begin
            case (rxByte)
              8'h01:   armTrigger   <= 1'b1;
              8'h02:   softReset    <= 1'b1;
              8'h03:   streamEnable <= 1'b1;
              8'h04:   streamEnable <= 1'b0;
              8'h10:   cmd_state    <= CMD_ADDR;
              default: cmdError     <= 1'b1;
            endcase
          end
        end
        CMD_ADDR, CMD_DATA: begin
          if (rxByteValid) begin
            if (cmd_state == CMD_ADDR) begin
              addr_latch <= rxByte;
              cmd_state  <= CMD_DATA;
            end else begin
              regAddr   <= addr_latch;
              regData   <= rxByte;
              regWrite  <= 1'b1;
              cmd_state <= CMD_IDLE;
            end
          end else if (framingError || to_cnt == TO_LAST) begin
            cmdError  <= 1'b1;
            cmd_state <= CMD_IDLE;
          end
        end
        default: cmd_state <= CMD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rxd_command_decoder.sv
// Bench for rxd_command_decoder: table of serial bytes with expected command
// events, checked against DUT pulses through an expected-event queue.
module tb_rxd_command_decoder;

  localparam int CPB = 16;
  localparam int TOB = 16;

  localparam int EV_NONE = 0;
  localparam int EV_RX   = 1;
  localparam int EV_FE   = 2;
  localparam int EV_ARM  = 3;
  localparam int EV_SRST = 4;
  localparam int EV_REGW = 5;
  localparam int EV_CERR = 6;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         cmd;
    logic [7:0] ra;
    logic [7:0] rd;
    logic       stream;
    logic [7:0] last_rx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdi = 1'b1;
  logic [7:0] rxByte, regAddr, regData;
  logic       rxByteValid, framingError, armTrigger, softReset;
  logic       streamEnable, regWrite, cmdError;

  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_rxv = 1'b0;
  ev_t  exp_q[$];
  vec_t vecs[15];

  rxd_command_decoder #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .SDI         (sdi),
    .rxByte      (rxByte),
    .rxByteValid (rxByteValid),
    .framingError(framingError),
    .armTrigger  (armTrigger),
    .softReset   (softReset),
    .streamEnable(streamEnable),
    .regAddr     (regAddr),
    .regData     (regData),
    .regWrite    (regWrite),
    .cmdError    (cmdError)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_RX && e.kind == EV_RX) check("rx_byte", a, e.a);
      if (kind == EV_REGW && e.kind == EV_REGW) begin
        check("reg_addr", a, e.a);
        check("reg_data", d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rxByteValid)  observe(EV_RX, rxByte, 8'h00);
      if (framingError) observe(EV_FE, 8'h00, 8'h00);
      if (armTrigger)   observe(EV_ARM, 8'h00, 8'h00);
      if (softReset)    observe(EV_SRST, 8'h00, 8'h00);
      if (regWrite)     observe(EV_REGW, regAddr, regData);
      if (cmdError)     observe(EV_CERR, 8'h00, 8'h00);
      if (armTrigger || softReset || regWrite) check("cmd_latency", prev_rxv, 1);
    end
    prev_rxv = rxByteValid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    sdi = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      sdi = b[i];
      repeat (CPB) @(posedge clk);
    end
    sdi = stop;
    repeat (CPB) @(posedge clk);
    sdi = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {rxByte, regAddr, regData, rxByteValid, framingError, armTrigger,
                 softReset, streamEnable, regWrite, cmdError}, 0);
  endtask

  initial begin
    vecs[0]  = '{8'hA5, 1'b1, EV_CERR, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[1]  = '{8'h03, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b1, 8'h03};
    vecs[2]  = '{8'h01, 1'b1, EV_ARM,  8'h00, 8'h00, 1'b1, 8'h01};
    vecs[3]  = '{8'h04, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h04};
    vecs[4]  = '{8'h10, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h10};
    vecs[5]  = '{8'h2C, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h2C};
    vecs[6]  = '{8'h7E, 1'b1, EV_REGW, 8'h2C, 8'h7E, 1'b0, 8'h7E};
    vecs[7]  = '{8'h10, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h10};
    vecs[8]  = '{8'h01, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h01};
    vecs[9]  = '{8'h33, 1'b1, EV_REGW, 8'h01, 8'h33, 1'b0, 8'h33};
    vecs[10] = '{8'h55, 1'b0, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h33};
    vecs[11] = '{8'h02, 1'b1, EV_SRST, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[12] = '{8'h03, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b1, 8'h03};
    vecs[13] = '{8'h02, 1'b1, EV_SRST, 8'h00, 8'h00, 1'b1, 8'h02};
    vecs[14] = '{8'h04, 1'b1, EV_NONE, 8'h00, 8'h00, 1'b0, 8'h04};

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all_zero("post_reset_idle");

    foreach (vecs[i]) begin
      push(vecs[i].stop ? EV_RX : EV_FE, vecs[i].data, 8'h00);
      if (vecs[i].cmd != EV_NONE) push(vecs[i].cmd, vecs[i].ra, vecs[i].rd);
      send_byte(vecs[i].data, vecs[i].stop);
      check("stream_level", streamEnable, vecs[i].stream);
      check("rx_byte_level", rxByte, vecs[i].last_rx);
    end

    // Inter-byte timeout in DATA phase, then a normal opcode still works.
    push(EV_RX, 8'h10, 8'h00);
    push(EV_RX, 8'h2C, 8'h00);
    push(EV_CERR, 8'h00, 8'h00);
    send_byte(8'h10, 1'b1);
    send_byte(8'h2C, 1'b1);
    repeat (TOB * CPB + 100) @(posedge clk);
    check("timeout_drained", exp_q.size(), 0);
    check("timeout_reg_addr", regAddr, 8'h01);
    check("timeout_reg_data", regData, 8'h33);
    push(EV_RX, 8'h01, 8'h00);
    push(EV_ARM, 8'h00, 8'h00);
    send_byte(8'h01, 1'b1);

    // Framing error while waiting for the address aborts the command.
    push(EV_RX, 8'h10, 8'h00);
    push(EV_FE, 8'h00, 8'h00);
    push(EV_CERR, 8'h00, 8'h00);
    send_byte(8'h10, 1'b1);
    send_byte(8'h55, 1'b0);
    check("fe_keeps_rx_byte", rxByte, 8'h10);

    // Short low glitch must not start a frame.
    @(posedge clk);
    sdi = 1'b0;
    repeat (2) @(posedge clk);
    sdi = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_no_event", exp_q.size(), 0);
    push(EV_RX, 8'hFF, 8'h00);
    push(EV_CERR, 8'h00, 8'h00);
    send_byte(8'hFF, 1'b1);
    check("glitch_then_ff", rxByte, 8'hFF);

    // Reset in the middle of a frame.
    push(EV_RX, 8'h03, 8'h00);
    send_byte(8'h03, 1'b1);
    check("stream_before_reset", streamEnable, 1);
    @(posedge clk);
    sdi = 1'b0;
    repeat (CPB) @(posedge clk);
    sdi = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    check("stream_after_reset", streamEnable, 0);
    push(EV_RX, 8'h01, 8'h00);
    push(EV_ARM, 8'h00, 8'h00);
    send_byte(8'h01, 1'b1);

    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
